// File: rtl/mc_pkg.sv
// Shared state encoding and opcode constants for the multi-cycle controller.
// The helper identifies the states that hold a memory request open.
package mc_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    function automatic logic is_wait_state(input logic [2:0] st);
        return (st == ST_FETCH) || (st == ST_MEM);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts request cycles without an acknowledge.
// expired flags the cycle whose missing ack would reach LIMIT; it is combinational and is gated by en.
module mem_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt;

    assign expired = en && (cnt == 8'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (en && !expired) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle CPU controller: FETCH/DECODE/EXEC/MEM/WB sequencing, memory wait timeout, retire counter.
// Optional single-step input is built when STEP_EN is defined; outputs depend on state and registers only.
module mc_control
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic [1:0]       Opcode,
    input  logic             Mem_Ack,
`ifdef STEP_EN
    input  logic             Step,
`endif
    output logic             Mem_Req,
    output logic             Mem_Write,
    output logic             IR_Load,
    output logic             PC_Inc,
    output logic             PC_Load,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             Clear,
    output logic             Busy,
    output logic             Timeout,
    output logic [CNT_W-1:0] Instr_Count
);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [2:0]       retire_nxt;
    logic [1:0]       op_q;
    logic             mem_req;
    logic             ack;
    logic             expired;
    logic             retire;
    logic             start;
    logic             resume;
    logic             timeout_q;
    logic             ir_load_q;
    logic             pc_inc_q;
    logic             pc_load_q;
    logic [CNT_W-1:0] cnt_q;

    assign mem_req = is_wait_state(state);
    assign ack     = mem_req && Mem_Ack;

    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .clr     (!(mem_req && !Mem_Ack)),
        .en      (mem_req && !Mem_Ack),
        .expired (expired)
    );

`ifdef STEP_EN
    logic step_q;
    logic single_q;
    logic step_rise;

    assign step_rise = Step && !step_q;
    assign start     = Run || step_rise;
    assign resume    = Run && !single_q;

    // A step edge seen in IDLE arms one-shot execution until the next retirement.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            step_q   <= 1'b0;
            single_q <= 1'b0;
        end else begin
            step_q <= Step;
            if ((state == ST_IDLE) && step_rise) begin
                single_q <= 1'b1;
            end else if (retire) begin
                single_q <= 1'b0;
            end
        end
    end
`else
    assign start  = Run;
    assign resume = Run;
`endif

    assign retire_nxt = resume ? ST_FETCH : ST_IDLE;

    assign retire = ((state == ST_DECODE) && (Opcode == OP_JMP)) ||
                    ((state == ST_MEM) && ack && (op_q == OP_SW)) ||
                    (state == ST_WB);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (ack)          state_nxt = ST_DECODE;
                else if (expired) state_nxt = ST_ERROR;
            end
            ST_DECODE: state_nxt = (Opcode == OP_JMP) ? retire_nxt : ST_EXEC;
            ST_EXEC:   state_nxt = (op_q == OP_ADD) ? ST_WB : ST_MEM;
            ST_MEM: begin
                // An ack on the expiring cycle takes priority over the timeout.
                if (ack)          state_nxt = (op_q == OP_SW) ? retire_nxt : ST_WB;
                else if (expired) state_nxt = ST_ERROR;
            end
            ST_WB:     state_nxt = retire_nxt;
            ST_ERROR:  state_nxt = ST_ERROR;
            default:   state_nxt = ST_ERROR;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_ADD;
            timeout_q <= 1'b0;
            ir_load_q <= 1'b0;
            pc_inc_q  <= 1'b0;
            pc_load_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_nxt;
            ir_load_q <= (state == ST_FETCH) && ack;
            pc_inc_q  <= (state == ST_FETCH) && ack;
            pc_load_q <= (state == ST_DECODE) && (Opcode == OP_JMP);
            if (state == ST_DECODE) begin
                op_q <= Opcode;
            end
            if (state_nxt == ST_ERROR) begin
                timeout_q <= 1'b1;
            end
            if (retire && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign Mem_Req     = mem_req;
    assign Mem_Write   = (state == ST_MEM) && (op_q == OP_SW);
    assign IR_Load     = ir_load_q;
    assign PC_Inc      = pc_inc_q;
    assign PC_Load     = pc_load_q;
    assign RegWrite    = (state == ST_WB);
    assign RegDst      = (state == ST_WB) && (op_q == OP_ADD);
    assign Clear       = (state != ST_WB);
    assign Busy        = (state != ST_IDLE) && (state != ST_ERROR);
    assign Timeout     = timeout_q;
    assign Instr_Count = cnt_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed table-driven bench for mc_control with a reactive memory model that acks on a chosen request cycle.
module tb_mc_control;
    import mc_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Run;
    logic [1:0] Opcode;
    logic       Mem_Ack;
`ifdef STEP_EN
    logic       Step;
`endif
    logic       Mem_Req, Mem_Write, IR_Load, PC_Inc, PC_Load;
    logic       RegDst, RegWrite, Clear, Busy, Timeout;
    logic [3:0] Instr_Count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    always #5 Clk = ~Clk;

    mc_control #(
        .MEM_TIMEOUT (15),
        .CNT_W       (4)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Run         (Run),
        .Opcode      (Opcode),
        .Mem_Ack     (Mem_Ack),
`ifdef STEP_EN
        .Step        (Step),
`endif
        .Mem_Req     (Mem_Req),
        .Mem_Write   (Mem_Write),
        .IR_Load     (IR_Load),
        .PC_Inc      (PC_Inc),
        .PC_Load     (PC_Load),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .Clear       (Clear),
        .Busy        (Busy),
        .Timeout     (Timeout),
        .Instr_Count (Instr_Count)
    );

    // fd/md: request cycle (1-based) on which the ack arrives in FETCH/MEM; 0 = never
    typedef struct {
        logic [1:0] op;
        int fd;
        int md;
        int busy;
        int req;
        int wr;
        int rw;
        int dst;
        int pcl;
    } vec_t;

    vec_t vecs[8];

    int n_busy, n_req, n_wr, n_rw, n_dst, n_clr, n_ir, n_inc, n_pcl;

    function automatic logic [9:0] outs();
        return {Mem_Req, Mem_Write, IR_Load, PC_Inc, PC_Load,
                RegDst, RegWrite, Clear, Busy, Timeout};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  stretch = 0;
        int  rlen    = 0;
        bit  in_req  = 0;
        bit  started = 0;
        bit  done    = 0;
        n_busy = 0; n_req = 0; n_wr = 0; n_rw = 0; n_dst = 0;
        n_clr  = 0; n_ir  = 0; n_inc = 0; n_pcl = 0;
        Opcode  = v.op;
        Run     = 1'b1;
        Mem_Ack = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge Clk);
            if (PC_Load) n_pcl++;
            if (started && !Busy) begin
                done = 1;
            end else begin
                if (Busy) begin
                    started = 1;
                    Run     = 1'b0;
                    n_busy++;
                end
                if (Mem_Req) begin
                    if (!in_req) begin
                        stretch++;
                        rlen = 0;
                    end
                    in_req = 1;
                    rlen++;
                    n_req++;
                    if (Mem_Write) n_wr++;
                end else begin
                    in_req = 0;
                end
                if (RegWrite) begin
                    n_rw++;
                    if (RegDst) n_dst++;
                    if (Clear)  n_clr++;
                end
                if (IR_Load) n_ir++;
                if (PC_Inc)  n_inc++;
                Mem_Ack = Mem_Req && (rlen == ((stretch == 1) ? v.fd : v.md));
            end
        end
        Mem_Ack = 1'b0;
        Run     = 1'b0;
        check("instr_completes", done, 1);
    endtask

    task automatic check_vec(input int i);
        exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
        check($sformatf("v%0d_busy_cycles", i), n_busy, vecs[i].busy);
        check($sformatf("v%0d_req_cycles", i), n_req, vecs[i].req);
        check($sformatf("v%0d_write_cycles", i), n_wr, vecs[i].wr);
        check($sformatf("v%0d_regwrite", i), n_rw, vecs[i].rw);
        check($sformatf("v%0d_regdst", i), n_dst, vecs[i].dst);
        check($sformatf("v%0d_clear_in_wb", i), n_clr, 0);
        check($sformatf("v%0d_ir_load", i), n_ir, 1);
        check($sformatf("v%0d_pc_inc", i), n_inc, 1);
        check($sformatf("v%0d_pc_load", i), n_pcl, vecs[i].pcl);
        check($sformatf("v%0d_timeout", i), Timeout, 0);
        check($sformatf("v%0d_instr_count", i), Instr_Count, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] busy_bits, ir_bits, pcl_bits;
        //             op      fd  md  busy req wr rw dst pcl
        vecs[0] = '{OP_ADD,  1,  0,  4,   1,  0, 1, 1,  0};
        vecs[1] = '{OP_LW,   1,  3,  7,   4,  0, 1, 0,  0};
        vecs[2] = '{OP_SW,   1,  1,  4,   2,  1, 0, 0,  0};
        vecs[3] = '{OP_JMP,  1,  0,  2,   1,  0, 0, 0,  1};
        vecs[4] = '{OP_ADD,  4,  0,  7,   4,  0, 1, 1,  0};
        vecs[5] = '{OP_SW,   2,  5,  9,   7,  5, 0, 0,  0};
        vecs[6] = '{OP_LW,  15, 15, 33,  30,  0, 1, 0,  0};
        vecs[7] = '{OP_LW,   2,  1,  6,   3,  0, 1, 0,  0};

`ifdef STEP_EN
        Step = 1'b0;
`endif
        Reset_n = 1'b0;
        Run     = 1'b0;
        Mem_Ack = 1'b0;
        Opcode  = OP_ADD;
        #3;
        check("reset_outputs", outs(), 10'b0000000100);
        check("reset_count", Instr_Count, 0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("idle_outputs", outs(), 10'b0000000100);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
            check_vec(i);
        end

        // Back-to-back JMPs with Run held high, Run dropped in the second DECODE
        Opcode = OP_JMP;
        Run    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            busy_bits[c] = Busy;
            ir_bits[c]   = IR_Load;
            pcl_bits[c]  = PC_Load;
            Mem_Ack      = Mem_Req;
            if (c == 3) Run = 1'b0;
        end
        Mem_Ack = 1'b0;
        exp_cnt = exp_cnt + 2;
        check("b2b_busy", busy_bits, 5'b01111);
        check("b2b_ir_load", ir_bits, 5'b01010);
        check("b2b_pc_load", pcl_bits, 5'b10100);
        check("b2b_count", Instr_Count, exp_cnt);

        // Counter saturates at all-ones
        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[3]);
            check_vec(3);
        end

        // Reset asserted between clock edges while in MEM
        Opcode = OP_LW;
        Run    = 1'b1;
        @(negedge Clk);
        Mem_Ack = 1'b1;
        Run     = 1'b0;
        @(negedge Clk);
        Mem_Ack = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("mid_mem_req", {Mem_Req, Busy}, 2'b11);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 10'b0000000100);
        check("async_reset_count", Instr_Count, 0);
        exp_cnt = 0;
        Mem_Ack = 1'b1;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        check("post_reset_ack_ignored", outs(), 10'b0000000100);
        Mem_Ack = 1'b0;

        // FETCH never acknowledged: timeout after 15 cycles
        run_vec('{OP_ADD, 0, 0, 15, 15, 0, 0, 0, 0});
        check("to_busy_cycles", n_busy, 15);
        check("to_req_cycles", n_req, 15);
        check("to_error_state", {Timeout, Mem_Req, Busy}, 3'b100);
        Mem_Ack = 1'b1;
        Run     = 1'b1;
        for (int c = 0; c < 3; c++) @(negedge Clk);
        check("late_ack_ignored", outs(), 10'b0000000101);
        check("late_ack_count", Instr_Count, 0);
        Mem_Ack = 1'b0;
        Run     = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        check("recover_reset", outs(), 10'b0000000100);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("recover_idle", outs(), 10'b0000000100);
        run_vec(vecs[0]);
        check_vec(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
